// File: rtl/decode_stage_pipelined_if.sv
// rtl/decode_stage_pipelined_if.sv - handshake and bus bundle for the pipelined decode stage
//
// Groups fetch-side input, writeback port and execute-side output of the
// decode stage. The slave modport is the decode stage; the master modport is
// whatever drives it (fetch, writeback and execute combined).
//   in_valid/in_ready/fetched_instruction : fetch handshake
//   flush                                 : squash held slot and incoming instruction
//   RegWrite/write_register_index/write_data : writeback port
//   out_valid/out_ready                   : execute handshake
//   opcode/rs/rt/rd/funct/read_data_1/read_data_2/extended_immediate : decoded slot
interface decode_stage_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           fetched_instruction;
  logic                  flush;
  logic                  RegWrite;
  logic [IDX_W-1:0]      write_register_index;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [5:0]            opcode;
  logic [IDX_W-1:0]      rs;
  logic [IDX_W-1:0]      rt;
  logic [IDX_W-1:0]      rd;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic [DATA_WIDTH-1:0] extended_immediate;

  modport slave (
    input  in_valid, fetched_instruction, flush, RegWrite, write_register_index,
           write_data, out_ready,
    output in_ready, out_valid, opcode, rs, rt, rd, funct, read_data_1, read_data_2,
           extended_immediate
  );

  modport master (
    output in_valid, fetched_instruction, flush, RegWrite, write_register_index,
           write_data, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, rd, funct, read_data_1, read_data_2,
           extended_immediate
  );
endinterface

// File: rtl/decode_stage_pipelined.sv
// rtl/decode_stage_pipelined.sv - MIPS decode stage with register file and one-entry output slot
//
// Splits the fetched instruction into fields, reads rs/rt from an internal
// register file (with write-read bypass) and extends the immediate. Results
// are held in a single registered slot with valid/ready on both sides.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : decode_stage_pipelined_if slave (fetch, writeback, execute sides)
module decode_stage_pipelined #(
  parameter int DATA_WIDTH         = 32,
  parameter int REG_COUNT          = 32,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input logic                     clock,
  input logic                     reset_n,
  decode_stage_pipelined_if.slave bus
);
  localparam int IDX_W = $clog2(REG_COUNT);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [IDX_W-1:0]      idx_t;

  data_t      regs_q [REG_COUNT];
  data_t      regs_d [REG_COUNT];

  logic       out_valid_q, out_valid_d;
  logic [5:0] opcode_q, opcode_d;
  idx_t       rs_q, rs_d;
  idx_t       rt_q, rt_d;
  idx_t       rd_q, rd_d;
  logic [5:0] funct_q, funct_d;
  data_t      rd1_q, rd1_d;
  data_t      rd2_q, rd2_d;
  data_t      imm_q, imm_d;

  logic       accept;
  logic       wr_en;
  idx_t       in_rs, in_rt, in_rd;
  logic [15:0] imm16;
  data_t      in_rd1, in_rd2, in_imm;
  logic       unused_instr_bits;

  // shamt and index bits above IDX_W are intentionally ignored
  assign unused_instr_bits = ^bus.fetched_instruction;

  assign in_rs = bus.fetched_instruction[21 +: IDX_W];
  assign in_rt = bus.fetched_instruction[16 +: IDX_W];
  assign in_rd = bus.fetched_instruction[11 +: IDX_W];
  assign imm16 = bus.fetched_instruction[15:0];

  // A write to the hardwired zero register is treated as no write at all,
  // so it neither commits, bypasses nor patches.
  assign wr_en = bus.RegWrite &&
                 !((ZERO_REG_HARDWIRED != 0) && (bus.write_register_index == '0));

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  // Register file write
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[bus.write_register_index] = bus.write_data;
  end

  // Operand reads with same-cycle writeback bypass
  always_comb begin
    in_rd1 = regs_q[in_rs];
    if ((ZERO_REG_HARDWIRED != 0) && (in_rs == '0)) in_rd1 = '0;
    else if (wr_en && (bus.write_register_index == in_rs)) in_rd1 = bus.write_data;
  end

  always_comb begin
    in_rd2 = regs_q[in_rt];
    if ((ZERO_REG_HARDWIRED != 0) && (in_rt == '0)) in_rd2 = '0;
    else if (wr_en && (bus.write_register_index == in_rt)) in_rd2 = bus.write_data;
  end

  // Immediate extension; the lui form is a 32-bit value cast to DATA_WIDTH
  always_comb begin
    case (bus.fetched_instruction[31:26])
      6'h0C, 6'h0D, 6'h0E: in_imm = data_t'(imm16);
      6'h0F:               in_imm = data_t'({imm16, 16'h0000});
      default:             in_imm = data_t'($signed(imm16));
    endcase
  end

  // Output slot
  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    funct_d     = funct_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    imm_d       = imm_q;

    if (bus.flush)          out_valid_d = 1'b0;
    else if (accept)        out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;

    if (accept) begin
      opcode_d = bus.fetched_instruction[31:26];
      rs_d     = in_rs;
      rt_d     = in_rt;
      rd_d     = in_rd;
      funct_d  = bus.fetched_instruction[5:0];
      rd1_d    = in_rd1;
      rd2_d    = in_rd2;
      imm_d    = in_imm;
    end else if (out_valid_q) begin
      // Keep a held slot coherent with writebacks that land after it was read
      if (wr_en && (bus.write_register_index == rs_q)) rd1_d = bus.write_data;
      if (wr_en && (bus.write_register_index == rt_q)) rd2_d = bus.write_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      funct_q     <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
    end else begin
      regs_q      <= regs_d;
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      funct_q     <= funct_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
    end
  end

  assign bus.out_valid          = out_valid_q;
  assign bus.opcode             = opcode_q;
  assign bus.rs                 = rs_q;
  assign bus.rt                 = rt_q;
  assign bus.rd                 = rd_q;
  assign bus.funct              = funct_q;
  assign bus.read_data_1        = rd1_q;
  assign bus.read_data_2        = rd2_q;
  assign bus.extended_immediate = imm_q;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// tb/tb_decode_stage_pipelined.sv - scoreboard bench for decode_stage_pipelined (32/32 and 16/8 builds)
module tb_decode_stage_pipelined;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n_a;
  logic reset_n_b;

  decode_stage_pipelined_if #(.DATA_WIDTH(32), .IDX_W(5)) bus_a ();
  decode_stage_pipelined_if #(.DATA_WIDTH(16), .IDX_W(3)) bus_b ();

  decode_stage_pipelined #(.DATA_WIDTH(32), .REG_COUNT(32), .ZERO_REG_HARDWIRED(1)) dut_a (
    .clock(clock), .reset_n(reset_n_a), .bus(bus_a)
  );
  decode_stage_pipelined #(.DATA_WIDTH(16), .REG_COUNT(8), .ZERO_REG_HARDWIRED(1)) dut_b (
    .clock(clock), .reset_n(reset_n_b), .bus(bus_b)
  );

  // op, rs, rt, rd, funct, read_data_1, read_data_2, extended_immediate
  typedef logic [122:0] exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   xfer_a = 0;
  int   xfer_b = 0;
  bit   done_b = 0;

  function automatic exp_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [5:0] f, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] imm);
    return {op, rs, rt, rd, f, r1, r2, imm};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t act_a();
    return mk(bus_a.opcode, bus_a.rs, bus_a.rt, bus_a.rd, bus_a.funct,
              bus_a.read_data_1, bus_a.read_data_2, bus_a.extended_immediate);
  endfunction

  function automatic exp_t act_b();
    return mk(bus_b.opcode, 5'(bus_b.rs), 5'(bus_b.rt), 5'(bus_b.rd), bus_b.funct,
              32'(bus_b.read_data_1), 32'(bus_b.read_data_2), 32'(bus_b.extended_immediate));
  endfunction

  // Monitors: pop and compare on every output transfer
  always @(negedge clock) begin
    if (reset_n_a && bus_a.out_valid && bus_a.out_ready) begin
      xfer_a++;
      if (q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_xfer_unexpected: got %h expected nothing", act_a());
      end else begin
        chk("a_xfer", act_a(), q_a.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n_b && bus_b.out_valid && bus_b.out_ready) begin
      xfer_b++;
      if (q_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_xfer_unexpected: got %h expected nothing", act_b());
      end else begin
        chk("b_xfer", act_b(), q_b.pop_front());
      end
    end
  end

  // ---------------- DUT A helpers ----------------
  task automatic tick_a();
    @(posedge clock); #1;
  endtask

  task automatic wr_a(input logic [4:0] idx, input logic [31:0] data);
    bus_a.RegWrite = 1'b1; bus_a.write_register_index = idx; bus_a.write_data = data;
    tick_a();
    bus_a.RegWrite = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] instr, input exp_t e, input bit rnd);
    bus_a.in_valid = 1'b1;
    bus_a.fetched_instruction = instr;
    for (int n = 0; n < 64; n++) begin
      if (rnd) bus_a.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus_a.in_ready && !bus_a.flush) begin
        q_a.push_back(e);
        tick_a();
        bus_a.in_valid = 1'b0;
        return;
      end
      tick_a();
    end
    tests++; fails++;
    $display("FAIL a_send_timeout: got no accept expected accept for %h", instr);
    bus_a.in_valid = 1'b0;
  endtask

  task automatic drain_a();
    bus_a.out_ready = 1'b1;
    for (int n = 0; n < 20 && q_a.size() != 0; n++) tick_a();
    tick_a();
  endtask

  // ---------------- DUT A sequence ----------------
  logic [31:0] sa_instr [8];
  exp_t        sa_exp   [8];
  exp_t        ex_pre, ex_post;
  int          xfer_start;

  initial begin
    bus_a.in_valid = 0; bus_a.fetched_instruction = 0; bus_a.flush = 0;
    bus_a.RegWrite = 0; bus_a.write_register_index = 0; bus_a.write_data = 0;
    bus_a.out_ready = 0;
    reset_n_a = 1'b0;
    tick_a(); tick_a();
    chk("a_reset_fields", 128'(act_a()), 128'(0));
    chk("a_reset_valid", 128'(bus_a.out_valid), 128'(0));
    chk("a_reset_in_ready", 128'(bus_a.in_ready), 128'(1));
    reset_n_a = 1'b1;
    tick_a();

    // load and basic decode
    wr_a(5, 32'h0000_1234);
    wr_a(6, 32'hFFFF_0000);
    bus_a.out_ready = 1'b1;
    send_a(32'h00A63820, mk(6'h00, 5, 6, 7, 6'h20, 32'h1234, 32'hFFFF0000, 32'h3820), 0);
    chk("a_latency_valid", 128'(bus_a.out_valid), 128'(1));

    // immediate modes
    send_a(32'h2085FFFC, mk(6'h08, 4, 5, 31, 6'h3C, 0, 32'h1234, 32'hFFFFFFFC), 0);
    send_a(32'h3485FFFC, mk(6'h0D, 4, 5, 31, 6'h3C, 0, 32'h1234, 32'h0000FFFC), 0);
    send_a(32'h3C058000, mk(6'h0F, 0, 5, 16, 6'h00, 0, 32'h1234, 32'h80000000), 0);

    // bypass: r5 written in the accept cycle
    bus_a.RegWrite = 1; bus_a.write_register_index = 5; bus_a.write_data = 32'hAAAA;
    send_a(32'h00A63820, mk(6'h00, 5, 6, 7, 6'h20, 32'hAAAA, 32'hFFFF0000, 32'h3820), 0);
    bus_a.RegWrite = 0;

    // zero register: neither bypassed nor committed
    wr_a(0, 32'h55);
    bus_a.RegWrite = 1; bus_a.write_register_index = 0; bus_a.write_data = 32'h99;
    send_a(32'h00053820, mk(6'h00, 0, 5, 7, 6'h20, 0, 32'hAAAA, 32'h3820), 0);
    bus_a.RegWrite = 0;
    tick_a();

    // stall with patch
    ex_pre  = mk(6'h00, 5, 6, 7, 6'h20, 32'hAAAA, 32'hFFFF0000, 32'h3820);
    ex_post = mk(6'h00, 5, 6, 7, 6'h20, 32'hAAAA, 32'h77, 32'h3820);
    bus_a.out_ready = 1'b0;
    send_a(32'h00A63820, ex_post, 0);
    chk("a_stall_in_ready", 128'(bus_a.in_ready), 128'(0));
    chk("a_stall_c1", 128'(act_a()), 128'(ex_pre));
    bus_a.in_valid = 1'b1; bus_a.fetched_instruction = 32'h00A63820;
    tick_a();
    chk("a_stall_c2", 128'(act_a()), 128'(ex_pre));
    bus_a.RegWrite = 1; bus_a.write_register_index = 6; bus_a.write_data = 32'h77;
    tick_a();
    bus_a.RegWrite = 0;
    chk("a_stall_patch", 128'(act_a()), 128'(ex_post));
    chk("a_stall_valid", 128'(bus_a.out_valid), 128'(1));
    bus_a.out_ready = 1'b1;
    #1;
    chk("a_release_in_ready", 128'(bus_a.in_ready), 128'(1));
    q_a.push_back(mk(6'h00, 5, 6, 7, 6'h20, 32'hAAAA, 32'h77, 32'h3820));
    tick_a();
    bus_a.in_valid = 1'b0;

    // flush with concurrent accept attempt and writeback
    bus_a.in_valid = 1; bus_a.fetched_instruction = 32'h3485FFFC; bus_a.flush = 1;
    bus_a.RegWrite = 1; bus_a.write_register_index = 7; bus_a.write_data = 32'h3333;
    tick_a();
    bus_a.in_valid = 0; bus_a.flush = 0; bus_a.RegWrite = 0;
    chk("a_flush_valid", 128'(bus_a.out_valid), 128'(0));
    send_a(32'h00E00020, mk(6'h00, 7, 0, 0, 6'h20, 32'h3333, 0, 32'h20), 0);
    drain_a();

    // streaming with random backpressure
    sa_instr[0] = 32'h00A63820; sa_exp[0] = mk(6'h00, 5, 6, 7, 6'h20, 32'hAAAA, 32'h77, 32'h3820);
    sa_instr[1] = 32'h2085FFFC; sa_exp[1] = mk(6'h08, 4, 5, 31, 6'h3C, 0, 32'hAAAA, 32'hFFFFFFFC);
    sa_instr[2] = 32'h3485FFFC; sa_exp[2] = mk(6'h0D, 4, 5, 31, 6'h3C, 0, 32'hAAAA, 32'h0000FFFC);
    sa_instr[3] = 32'h3C058000; sa_exp[3] = mk(6'h0F, 0, 5, 16, 6'h00, 0, 32'hAAAA, 32'h80000000);
    sa_instr[4] = 32'h00E00020; sa_exp[4] = mk(6'h00, 7, 0, 0, 6'h20, 32'h3333, 0, 32'h20);
    sa_instr[5] = 32'h30C7000F; sa_exp[5] = mk(6'h0C, 6, 7, 0, 6'h0F, 32'h77, 32'h3333, 32'h0F);
    sa_instr[6] = 32'h38A68001; sa_exp[6] = mk(6'h0E, 5, 6, 16, 6'h01, 32'hAAAA, 32'h77, 32'h8001);
    sa_instr[7] = 32'h8CA6FFFF; sa_exp[7] = mk(6'h23, 5, 6, 31, 6'h3F, 32'hAAAA, 32'h77, 32'hFFFFFFFF);
    xfer_start = xfer_a;
    for (int i = 0; i < 8; i++) send_a(sa_instr[i], sa_exp[i], 1);
    drain_a();
    chk("a_stream_count", 128'(xfer_a - xfer_start), 128'(8));
    chk("a_queue_empty", 128'(q_a.size()), 128'(0));

    // reset while a slot is stalled discards it
    bus_a.out_ready = 0; bus_a.in_valid = 1; bus_a.fetched_instruction = 32'h00A63820;
    tick_a();
    bus_a.in_valid = 0;
    chk("a_held_valid", 128'(bus_a.out_valid), 128'(1));
    reset_n_a = 1'b0;
    #1;
    chk("a_midreset_valid", 128'(bus_a.out_valid), 128'(0));
    chk("a_midreset_fields", 128'(act_a()), 128'(0));
    tick_a();
    reset_n_a = 1'b1;
    tick_a();

    for (int n = 0; n < 2000 && !done_b; n++) tick_a();
    if (!done_b) begin
      tests++; fails++;
      $display("FAIL b_done_timeout: got not done expected done");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- DUT B (16-bit data, 8 registers) ----------------
  task automatic tick_b();
    @(posedge clock); #1;
  endtask

  logic [31:0] sb_instr [8];
  exp_t        sb_exp   [8];

  initial begin
    bus_b.in_valid = 0; bus_b.fetched_instruction = 0; bus_b.flush = 0;
    bus_b.RegWrite = 0; bus_b.write_register_index = 0; bus_b.write_data = 0;
    bus_b.out_ready = 0;
    reset_n_b = 1'b0;
    tick_b(); tick_b();
    chk("b_reset_fields", 128'(act_b()), 128'(0));
    chk("b_reset_valid", 128'(bus_b.out_valid), 128'(0));
    reset_n_b = 1'b1;
    tick_b();
    bus_b.RegWrite = 1; bus_b.write_register_index = 5; bus_b.write_data = 16'h1234;
    tick_b();
    bus_b.write_register_index = 6; bus_b.write_data = 16'hBEEF;
    tick_b();
    bus_b.RegWrite = 0;

    sb_instr[0] = 32'h00A63820; sb_exp[0] = mk(6'h00, 5, 6, 7, 6'h20, 32'h1234, 32'hBEEF, 32'h3820);
    sb_instr[1] = 32'h2085FFFC; sb_exp[1] = mk(6'h08, 4, 5, 7, 6'h3C, 0, 32'h1234, 32'hFFFC);
    sb_instr[2] = 32'h3485FFFC; sb_exp[2] = mk(6'h0D, 4, 5, 7, 6'h3C, 0, 32'h1234, 32'hFFFC);
    sb_instr[3] = 32'h3C058000; sb_exp[3] = mk(6'h0F, 0, 5, 0, 6'h00, 0, 32'h1234, 32'h0000);
    sb_instr[4] = 32'h8CA6FFFF; sb_exp[4] = mk(6'h23, 5, 6, 7, 6'h3F, 32'h1234, 32'hBEEF, 32'hFFFF);
    sb_instr[5] = 32'h01C00020; sb_exp[5] = mk(6'h00, 6, 0, 0, 6'h20, 32'hBEEF, 0, 32'h0020);
    sb_instr[6] = 32'h00E00020; sb_exp[6] = mk(6'h00, 7, 0, 0, 6'h20, 0, 0, 32'h0020);
    sb_instr[7] = 32'h30C7000F; sb_exp[7] = mk(6'h0C, 6, 7, 0, 6'h0F, 32'hBEEF, 0, 32'h000F);

    for (int i = 0; i < 8; i++) begin
      bit ok;
      ok = 0;
      bus_b.in_valid = 1'b1;
      bus_b.fetched_instruction = sb_instr[i];
      for (int n = 0; n < 64 && !ok; n++) begin
        bus_b.out_ready = 1'($urandom_range(0, 1));
        #1;
        if (bus_b.in_ready) begin
          q_b.push_back(sb_exp[i]);
          ok = 1;
        end
        tick_b();
      end
      bus_b.in_valid = 1'b0;
      if (!ok) begin
        tests++; fails++;
        $display("FAIL b_send_timeout: got no accept expected accept for %h", sb_instr[i]);
      end
    end
    bus_b.out_ready = 1'b1;
    for (int n = 0; n < 20 && q_b.size() != 0; n++) tick_b();
    tick_b();
    chk("b_stream_count", 128'(xfer_b), 128'(8));
    chk("b_queue_empty", 128'(q_b.size()), 128'(0));
    done_b = 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
